// File: rtl/wave_generator_high.sv
// wave_generator_high: burst square-wave stimulus source.
// A configuration request latches a half-period, an amplitude and a period count.
// The block then emits one signed 16-bit sample per clock on both channels:
// half_period clocks at the hi level, then half_period clocks at the lo level,
// repeated. Both levels are centred on the MID DC level.
// Optional feature macro: WAVE_GEN_RGHT_INV_EN. When it is defined, the right
// channel is the left channel mirrored about MID while a burst runs.
// Handshake: a request is taken on a rising edge where cfg_vld && cfg_rdy.
// cfg_rdy is high only in IDLE, and cfg_vld at any other time has no effect.
// dbg_state exposes the FSM state for checkers.
module wave_generator_high #(
   parameter int MID      = 567,
   parameter int MIN_HALF = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_vld,
   output logic               cfg_rdy,
   input  logic [21:0]        half_period,
   input  logic [11:0]        amp,
   input  logic [7:0]         n_cycles,
   input  logic               stop,
   output logic signed [15:0] lft_out,
   output logic signed [15:0] rght_out,
   output logic               smpl_vld,
   output logic               busy,
   output logic               done,
   output logic               cfg_err,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

   localparam logic signed [15:0] MID16      = 16'(MID);
   localparam logic [21:0]        MIN_HALF22 = 22'(MIN_HALF);

   state_t             state;
   logic [21:0]        hp_r;
   logic [21:0]        cnt;
   logic [7:0]         nc_r;
   logic [7:0]         per_cnt;
   logic signed [15:0] hi_r;
   logic signed [15:0] lo_r;
   logic signed [15:0] half_amp;
   logic signed [15:0] odd_amp;
   logic signed [15:0] hi_new;
   logic signed [15:0] lo_new;
   logic               cnt_end;
   logic               last_period;

   // Right-channel value for a given left-channel level
   function automatic logic signed [15:0] rght_of(input logic signed [15:0] v);
`ifdef WAVE_GEN_RGHT_INV_EN
      rght_of = MID16 + MID16 - v;
`else
      rght_of = v;
`endif
   endfunction

   // Burst levels from the requested amplitude. The odd LSB goes to hi, so hi - lo == amp
   always_comb begin
      half_amp = {5'd0, amp[11:1]};
      odd_amp  = {15'd0, amp[0]};
      hi_new   = MID16 + half_amp + odd_amp;
      lo_new   = MID16 - half_amp;
   end

   assign cnt_end     = (cnt == hp_r - 22'd1);
   assign last_period = (nc_r != 8'd0) && (per_cnt == nc_r - 8'd1);
   assign dbg_state   = state;

   // FSM with registered outputs: accept or reject requests, sequence the hi/lo half-periods
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         hp_r     <= '0;
         nc_r     <= '0;
         cnt      <= '0;
         per_cnt  <= '0;
         hi_r     <= MID16;
         lo_r     <= MID16;
         lft_out  <= MID16;
         rght_out <= MID16;
         smpl_vld <= 1'b0;
         busy     <= 1'b0;
         cfg_rdy  <= 1'b1;
         done     <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_vld && cfg_rdy) begin
                  if (half_period < MIN_HALF22) begin
                     cfg_err <= 1'b1;
                  end else begin
                     hp_r     <= half_period;
                     nc_r     <= n_cycles;
                     hi_r     <= hi_new;
                     lo_r     <= lo_new;
                     cnt      <= '0;
                     per_cnt  <= '0;
                     state    <= HIGH;
                     lft_out  <= hi_new;
                     rght_out <= rght_of(hi_new);
                     smpl_vld <= 1'b1;
                     busy     <= 1'b1;
                     cfg_rdy  <= 1'b0;
                  end
               end
            end
            HIGH: begin
               if (stop) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  lft_out  <= MID16;
                  rght_out <= MID16;
                  smpl_vld <= 1'b0;
                  busy     <= 1'b0;
                  cfg_rdy  <= 1'b1;
                  done     <= 1'b1;
               end else if (cnt_end) begin
                  cnt      <= '0;
                  state    <= LOW;
                  lft_out  <= lo_r;
                  rght_out <= rght_of(lo_r);
               end else begin
                  cnt <= cnt + 22'd1;
               end
            end
            LOW: begin
               if (stop || (cnt_end && last_period)) begin
                  // A stop that coincides with the natural end still gives one done pulse
                  state    <= IDLE;
                  cnt      <= '0;
                  lft_out  <= MID16;
                  rght_out <= MID16;
                  smpl_vld <= 1'b0;
                  busy     <= 1'b0;
                  cfg_rdy  <= 1'b1;
                  done     <= 1'b1;
               end else if (cnt_end) begin
                  // Continuous mode lets the period counter wrap harmlessly
                  cnt      <= '0;
                  per_cnt  <= per_cnt + 8'd1;
                  state    <= HIGH;
                  lft_out  <= hi_r;
                  rght_out <= rght_of(hi_r);
               end else begin
                  cnt <= cnt + 22'd1;
               end
            end
            default: begin
               state    <= IDLE;
               cnt      <= '0;
               lft_out  <= MID16;
               rght_out <= MID16;
               smpl_vld <= 1'b0;
               busy     <= 1'b0;
               cfg_rdy  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wave_generator_high.sv
// Testbench for wave_generator_high. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge. Expected waveforms come from a
// queue built from the level/timing rules with plain arithmetic.
module tb_wave_generator_high;

   localparam int MID = 567;

   logic               clk = 1'b0;
   logic               rst;
   logic               cfg_vld;
   logic               cfg_rdy;
   logic [21:0]        half_period;
   logic [11:0]        amp;
   logic [7:0]         n_cycles;
   logic               stop;
   logic signed [15:0] lft_out;
   logic signed [15:0] rght_out;
   logic               smpl_vld;
   logic               busy;
   logic               done;
   logic               cfg_err;
   logic [1:0]         dbg_state;

   int n_cmp = 0;
   int n_bad = 0;
   int done_seen = 0;
   logic [15:0] exp_q[$];

   wave_generator_high #(.MID(MID), .MIN_HALF(2)) dut (
      .clk(clk), .rst(rst), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
      .half_period(half_period), .amp(amp), .n_cycles(n_cycles), .stop(stop),
      .lft_out(lft_out), .rght_out(rght_out), .smpl_vld(smpl_vld), .busy(busy),
      .done(done), .cfg_err(cfg_err), .dbg_state(dbg_state)
   );

   // clock and done-pulse counter
   always #5 clk = ~clk;
   always @(negedge clk) if (done === 1'b1) done_seen++;

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   // Reference model: full expected left-channel sequence for a burst
   task automatic build_model(input int hp, input int a, input int periods);
      int hi, lo;
      hi = MID + a / 2 + a % 2;
      lo = MID - a / 2;
      exp_q.delete();
      for (int p = 0; p < periods; p++) begin
         for (int i = 0; i < hp; i++) exp_q.push_back(16'(hi));
         for (int i = 0; i < hp; i++) exp_q.push_back(16'(lo));
      end
   endtask

   function automatic logic [15:0] exp_r(input logic [15:0] l);
`ifdef WAVE_GEN_RGHT_INV_EN
      return 16'(2 * MID) - l;
`else
      return l;
`endif
   endfunction

   // driver: present a request for one cycle starting at this falling edge
   task automatic drive_cfg(input int hp, input int a, input int n);
      cfg_vld     = 1'b1;
      half_period = 22'(hp);
      amp         = 12'(a);
      n_cycles    = 8'(n);
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_vld = 1'b0; stop = 1'b0;
      half_period = '0; amp = '0; n_cycles = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (lft_out !== 16'(MID) || rght_out !== 16'(MID) || smpl_vld !== 1'b0 || busy !== 1'b0 ||
          cfg_rdy !== 1'b1 || done !== 1'b0 || cfg_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: lft=%0d rght=%0d vld=%b busy=%b rdy=%b done=%b err=%b, want 567 567 0 0 1 0 0",
                  lft_out, rght_out, smpl_vld, busy, cfg_rdy, done, cfg_err);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [15:0] e;
      int n;
      drive_cfg(4, 100, 2);
      @(negedge clk);
      cfg_vld = 1'b0;
      build_model(4, 100, 2);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (smpl_vld !== 1'b1 || busy !== 1'b1 || lft_out !== e || rght_out !== exp_r(e)) begin
            n_bad++;
            $display("FAIL basic_sample %0d: lft=%0d rght=%0d vld=%b, want lft=%0d rght=%0d vld=1",
                     i, lft_out, rght_out, smpl_vld, e, exp_r(e));
         end
         @(negedge clk);
      end
      n_cmp++;
      if (done !== 1'b1 || cfg_rdy !== 1'b1 || lft_out !== 16'(MID) || smpl_vld !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_done: done=%b rdy=%b lft=%0d vld=%b, want 1 1 567 0", done, cfg_rdy, lft_out, smpl_vld);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_done_width: done=%b, want 0", done);
      end
   endtask

   task automatic test_odd_amp();
      logic [15:0] e;
      drive_cfg(3, 101, 1);
      @(negedge clk);
      cfg_vld = 1'b0;
      n_cmp++;
      if (lft_out !== 16'd618) begin
         n_bad++;
         $display("FAIL odd_amp_hi: lft=%0d, want 618", lft_out);
      end
      build_model(3, 101, 1);
      for (int i = 0; i < 6; i++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (smpl_vld !== 1'b1 || lft_out !== e || rght_out !== exp_r(e)) begin
            n_bad++;
            $display("FAIL odd_amp_sample %0d: lft=%0d rght=%0d vld=%b, want lft=%0d rght=%0d vld=1",
                     i, lft_out, rght_out, smpl_vld, e, exp_r(e));
         end
         @(negedge clk);
      end
      n_cmp++;
      if (done !== 1'b1 || smpl_vld !== 1'b0) begin
         n_bad++;
         $display("FAIL odd_amp_done: done=%b vld=%b, want 1 0", done, smpl_vld);
      end
      @(negedge clk);
   endtask

   task automatic test_reject();
      logic [15:0] e;
      drive_cfg(1, 200, 1);
      @(negedge clk);
      cfg_vld = 1'b0;
      n_cmp++;
      if (cfg_err !== 1'b1 || smpl_vld !== 1'b0 || cfg_rdy !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reject_pulse: err=%b vld=%b rdy=%b busy=%b, want 1 0 1 0", cfg_err, smpl_vld, cfg_rdy, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (cfg_err !== 1'b0 || smpl_vld !== 1'b0) begin
         n_bad++;
         $display("FAIL reject_width: err=%b vld=%b, want 0 0", cfg_err, smpl_vld);
      end
      drive_cfg(2, 40, 1);
      @(negedge clk);
      cfg_vld = 1'b0;
      build_model(2, 40, 1);
      for (int i = 0; i < 4; i++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (smpl_vld !== 1'b1 || lft_out !== e || cfg_err !== 1'b0) begin
            n_bad++;
            $display("FAIL min_half_sample %0d: lft=%0d vld=%b err=%b, want lft=%0d vld=1 err=0",
                     i, lft_out, smpl_vld, cfg_err, e);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++;
         $display("FAIL min_half_done: done=%b, want 1", done);
      end
      @(negedge clk);
   endtask

   task automatic test_random_bursts();
      logic [15:0] e;
      int hp, a, nc, n;
      for (int t = 0; t < 5; t++) begin
         hp = $urandom_range(2, 6);
         a  = (t == 0) ? 0 : $urandom_range(0, 4095);
         nc = $urandom_range(1, 3);
         drive_cfg(hp, a, nc);
         @(negedge clk);
         cfg_vld = 1'b0;
         build_model(hp, a, nc);
         n = exp_q.size();
         for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (smpl_vld !== 1'b1 || lft_out !== e || rght_out !== exp_r(e)) begin
               n_bad++;
               $display("FAIL rand_sample t%0d i%0d (hp=%0d amp=%0d n=%0d): lft=%0d rght=%0d vld=%b, want %0d %0d 1",
                        t, i, hp, a, nc, lft_out, rght_out, smpl_vld, e, exp_r(e));
            end
            @(negedge clk);
         end
         n_cmp++;
         if (done !== 1'b1 || smpl_vld !== 1'b0 || lft_out !== 16'(MID)) begin
            n_bad++;
            $display("FAIL rand_end t%0d: done=%b vld=%b lft=%0d, want 1 0 567", t, done, smpl_vld, lft_out);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_continuous_stop(input int hp, input int stop_cyc);
      logic [15:0] e;
      int a, base;
      a = $urandom_range(1, 4095);
      base = done_seen;
      drive_cfg(hp, a, 0);
      @(negedge clk);
      cfg_vld = 1'b0;
      build_model(hp, a, (stop_cyc / (2 * hp)) + 2);
      for (int i = 1; i <= stop_cyc; i++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (smpl_vld !== 1'b1 || lft_out !== e || done !== 1'b0) begin
            n_bad++;
            $display("FAIL cont_sample hp%0d c%0d: lft=%0d vld=%b done=%b, want %0d 1 0", hp, i, lft_out, smpl_vld, done, e);
         end
         if (i == stop_cyc) stop = 1'b1;
         @(negedge clk);
      end
      stop = 1'b0;
      n_cmp++;
      if (lft_out !== 16'(MID) || rght_out !== 16'(MID) || smpl_vld !== 1'b0 || done !== 1'b1 || cfg_rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL cont_stop hp%0d: lft=%0d rght=%0d vld=%b done=%b rdy=%b, want 567 567 0 1 1",
                  hp, lft_out, rght_out, smpl_vld, done, cfg_rdy);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (done_seen - base !== 1) begin
         n_bad++;
         $display("FAIL cont_done_count hp%0d: got %0d pulses, want 1", hp, done_seen - base);
      end
   endtask

   task automatic test_stop_at_end();
      logic [15:0] e;
      int base;
      base = done_seen;
      drive_cfg(3, 60, 1);
      @(negedge clk);
      cfg_vld = 1'b0;
      build_model(3, 60, 1);
      for (int i = 1; i <= 6; i++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (smpl_vld !== 1'b1 || lft_out !== e) begin
            n_bad++;
            $display("FAIL stop_end_sample %0d: lft=%0d vld=%b, want %0d 1", i, lft_out, smpl_vld, e);
         end
         if (i == 6) stop = 1'b1;
         @(negedge clk);
      end
      stop = 1'b0;
      n_cmp++;
      if (done !== 1'b1 || smpl_vld !== 1'b0) begin
         n_bad++;
         $display("FAIL stop_end_done: done=%b vld=%b, want 1 0", done, smpl_vld);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (done_seen - base !== 1) begin
         n_bad++;
         $display("FAIL stop_end_count: got %0d pulses, want 1", done_seen - base);
      end
   endtask

   task automatic test_busy_ignore();
      logic [15:0] e;
      int a;
      a = $urandom_range(0, 4095);
      drive_cfg(4, a, 2);
      @(negedge clk);
      cfg_vld = 1'b0;
      build_model(4, a, 2);
      for (int i = 0; i < 16; i++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (smpl_vld !== 1'b1 || lft_out !== e || cfg_err !== 1'b0 || cfg_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_sample %0d: lft=%0d vld=%b err=%b rdy=%b, want %0d 1 0 0",
                     i, lft_out, smpl_vld, cfg_err, cfg_rdy, e);
         end
         if (i == 5) drive_cfg(1, 4095, 7);
         if (i == 6) cfg_vld = 1'b0;
         @(negedge clk);
      end
      n_cmp++;
      if (done !== 1'b1 || cfg_err !== 1'b0) begin
         n_bad++;
         $display("FAIL busy_done: done=%b err=%b, want 1 0", done, cfg_err);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_low();
      logic [15:0] e;
      int base;
      drive_cfg(4, 100, 2);
      @(negedge clk);
      cfg_vld = 1'b0;
      build_model(4, 100, 2);
      for (int i = 0; i < 6; i++) begin
         e = exp_q.pop_front();
         @(negedge clk);
      end
      base = done_seen;
      n_cmp++;
      if (lft_out !== 16'd517 || smpl_vld !== 1'b1) begin
         n_bad++;
         $display("FAIL pre_reset_low: lft=%0d vld=%b, want 517 1", lft_out, smpl_vld);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (lft_out !== 16'(MID) || rght_out !== 16'(MID) || smpl_vld !== 1'b0 || cfg_rdy !== 1'b1 ||
          done !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid_low: lft=%0d rght=%0d vld=%b rdy=%b done=%b busy=%b, want 567 567 0 1 0 0",
                  lft_out, rght_out, smpl_vld, cfg_rdy, done, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (done_seen - base !== 0 || smpl_vld !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_no_done: pulses=%0d vld=%b, want 0 0", done_seen - base, smpl_vld);
      end
      drive_cfg(2, 10, 1);
      @(negedge clk);
      cfg_vld = 1'b0;
      build_model(2, 10, 1);
      for (int i = 0; i < 4; i++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (smpl_vld !== 1'b1 || lft_out !== e) begin
            n_bad++;
            $display("FAIL post_reset_sample %0d: lft=%0d vld=%b, want %0d 1", i, lft_out, smpl_vld, e);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++;
         $display("FAIL post_reset_done: done=%b, want 1", done);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [15:0] e;
      int hp2, a2;
      hp2 = $urandom_range(2, 5);
      a2  = $urandom_range(0, 4095);
      drive_cfg(2, 300, 1);
      @(negedge clk);
      cfg_vld = 1'b0;
      build_model(2, 300, 1);
      for (int i = 0; i < 4; i++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (smpl_vld !== 1'b1 || lft_out !== e) begin
            n_bad++;
            $display("FAIL b2b_first %0d: lft=%0d vld=%b, want %0d 1", i, lft_out, smpl_vld, e);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (done !== 1'b1 || cfg_rdy !== 1'b1 || lft_out !== 16'(MID) || smpl_vld !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_gap: done=%b rdy=%b lft=%0d vld=%b, want 1 1 567 0", done, cfg_rdy, lft_out, smpl_vld);
      end
      drive_cfg(hp2, a2, 1);
      @(negedge clk);
      cfg_vld = 1'b0;
      build_model(hp2, a2, 1);
      for (int i = 0; i < 2 * hp2; i++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (smpl_vld !== 1'b1 || lft_out !== e || rght_out !== exp_r(e)) begin
            n_bad++;
            $display("FAIL b2b_second %0d: lft=%0d rght=%0d vld=%b, want %0d %0d 1",
                     i, lft_out, rght_out, smpl_vld, e, exp_r(e));
         end
         @(negedge clk);
      end
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_second_done: done=%b, want 1", done);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_odd_amp();
      test_reject();
      test_random_bursts();
      test_continuous_stop(5, 37);
      test_continuous_stop($urandom_range(2, 7), $urandom_range(10, 60));
      test_stop_at_end();
      test_busy_ignore();
      test_reset_mid_low();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
